// File: rtl/freq_sel_pkg.sv
// Shared definitions for the frequency-select path: code values used by the
// clock multiplexer select logic, the detector FSM encoding and a helper
// that sizes the period counter from the system clock frequency.
package freq_sel_pkg;

  // Frequency-select codes, shared with the multiplexer select logic
  localparam logic [1:0] FREQ_1HZ  = 2'b00;
  localparam logic [1:0] FREQ_4HZ  = 2'b01;
  localparam logic [1:0] FREQ_8HZ  = 2'b10;
  localparam logic [1:0] FREQ_16HZ = 2'b11;

  // Detector FSM: idle until the first edge, then measure edge-to-edge
  typedef enum logic {
    S_WAIT    = 1'b0,
    S_MEASURE = 1'b1
  } det_state_t;

  // Period counter width: must hold the timeout value of two seconds
  function automatic int cnt_width(input int clk_hz);
    return $clog2(2 * clk_hz + 1);
  endfunction

endpackage

// File: rtl/freq_detector_if.sv
// Bundle between the detector and its consumer (status display / self-check).
// The slow clock under test enters through here; the detector drives the rest.
interface freq_detector_if #(
  parameter int CNT_W = 27
);

  logic             clk_selected;
  logic [1:0]       freq_code;
  logic             code_valid;
  logic             code_change;
  logic [CNT_W-1:0] period_count;
  logic             sig_lost;

  // Detector side
  modport master (
    input  clk_selected,
    output freq_code,
    output code_valid,
    output code_change,
    output period_count,
    output sig_lost
  );

  // Consumer side (also supplies the slow clock)
  modport slave (
    output clk_selected,
    input  freq_code,
    input  code_valid,
    input  code_change,
    input  period_count,
    input  sig_lost
  );

endinterface

// File: rtl/sync_edge_detect.sv
// Brings an asynchronous slow clock into the clk domain through two flops,
// then emits a registered one-cycle pulse per rising edge. The pulse appears
// three clk edges after the pin edge.
module sync_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic sig_async,
  output logic rise
);

  logic meta_reg;
  logic sync_reg;
  logic prev_reg;
  logic rise_reg;

  // Two-stage synchroniser, delayed copy, and registered rising-edge pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
      prev_reg <= 1'b0;
      rise_reg <= 1'b0;
    end else begin
      meta_reg <= sig_async;
      sync_reg <= meta_reg;
      prev_reg <= sync_reg;
      rise_reg <= sync_reg & ~prev_reg;
    end
  end

  assign rise = rise_reg;

endmodule

// File: rtl/freq_detector.sv
// Measures the period of the selected slow clock in clk cycles, classifies it
// into one of the four select codes and reports a code only once CONFIRM
// consecutive periods agree. A missing clock for TIMEOUT cycles raises
// sig_lost and drops code_valid while the last code is kept.
module freq_detector #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int CONFIRM = 2
) (
  input  logic            clk,
  input  logic            rst,
  freq_detector_if.master bus
);

  import freq_sel_pkg::*;

  localparam int CNT_W = cnt_width(CLK_HZ);

  // Class boundaries sit between the nominal periods; equality goes faster
  localparam logic [CNT_W-1:0] TH_A    = CNT_W'(3 * CLK_HZ / 32);
  localparam logic [CNT_W-1:0] TH_B    = CNT_W'(3 * CLK_HZ / 16);
  localparam logic [CNT_W-1:0] TH_C    = CNT_W'(5 * CLK_HZ / 8);
  localparam logic [CNT_W-1:0] MIN_P   = CNT_W'(CLK_HZ / 32);
  localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(2 * CLK_HZ);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [2:0]       CONF_MAX = 3'(CONFIRM);

  logic rise;

  det_state_t       state_reg,  state_next;
  logic [CNT_W-1:0] cnt_reg,    cnt_next;
  logic [1:0]       cand_reg,   cand_next;
  logic [2:0]       conf_reg,   conf_next;
  logic [1:0]       code_reg,   code_next;
  logic             valid_reg,  valid_next;
  logic             change_reg, change_next;
  logic [CNT_W-1:0] period_reg, period_next;
  logic             lost_reg,   lost_next;

  logic             glitch;
  logic [1:0]       cls;

  sync_edge_detect u_sync (
    .clk       (clk),
    .rst       (rst),
    .sig_async (bus.clk_selected),
    .rise      (rise)
  );

  // Classify the period currently held in the counter (used on rise cycles)
  always_comb begin
    glitch = (cnt_reg < MIN_P);
    cls    = FREQ_1HZ;
    if (cnt_reg <= TH_A) begin
      cls = FREQ_16HZ;
    end else if (cnt_reg <= TH_B) begin
      cls = FREQ_8HZ;
    end else if (cnt_reg <= TH_C) begin
      cls = FREQ_4HZ;
    end
  end

  // State and output registers; reset discards any measurement in progress
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= S_WAIT;
      cnt_reg    <= '0;
      cand_reg   <= FREQ_1HZ;
      conf_reg   <= '0;
      code_reg   <= FREQ_1HZ;
      valid_reg  <= 1'b0;
      change_reg <= 1'b0;
      period_reg <= '0;
      lost_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      cand_reg   <= cand_next;
      conf_reg   <= conf_next;
      code_reg   <= code_next;
      valid_reg  <= valid_next;
      change_reg <= change_next;
      period_reg <= period_next;
      lost_reg   <= lost_next;
    end
  end

  // Next-state logic: counting, confirmation, code update and timeout
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    cand_next   = cand_reg;
    conf_next   = conf_reg;
    code_next   = code_reg;
    valid_next  = valid_reg;
    change_next = 1'b0;
    period_next = period_reg;
    lost_next   = lost_reg;

    case (state_reg)
      S_WAIT: begin
        // First edge only starts the measurement; there is no period yet
        if (rise) begin
          state_next = S_MEASURE;
          cnt_next   = CNT_ONE;
          lost_next  = 1'b0;
        end
      end

      S_MEASURE: begin
        if (rise) begin
          // A rise coinciding with saturation still counts as a period
          cnt_next  = CNT_ONE;
          lost_next = 1'b0;
          if (glitch) begin
            conf_next = '0;
          end else begin
            period_next = cnt_reg;
            if (cls == cand_reg) begin
              conf_next = (conf_reg >= CONF_MAX) ? CONF_MAX : conf_reg + 3'd1;
            end else begin
              cand_next = cls;
              conf_next = 3'd1;
            end
            // Publish only a newly confirmed code or a re-lock after loss
            if (conf_next >= CONF_MAX && (cls != code_reg || !valid_reg)) begin
              code_next   = cls;
              valid_next  = 1'b1;
              change_next = 1'b1;
            end
          end
        end else if (cnt_reg == TIMEOUT) begin
          // Clock lost: keep the last code but stop vouching for it
          state_next = S_WAIT;
          valid_next = 1'b0;
          lost_next  = 1'b1;
          conf_next  = '0;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end

      default: begin
        state_next = S_WAIT;
      end
    endcase
  end

  assign bus.freq_code    = code_reg;
  assign bus.code_valid   = valid_reg;
  assign bus.code_change  = change_reg;
  assign bus.period_count = period_reg;
  assign bus.sig_lost     = lost_reg;

endmodule

// File: doc/freq_detector.md
Name: freq_detector

Overview:
- Recovers the 2-bit frequency-select code from the output of the clock multiplexer (1/4/8/16 Hz), using the fast system clock to time it.
- Synchronises the selected slow clock, measures each rising-edge-to-rising-edge period, and classifies it.
- A code is reported only after consecutive periods agree. Loss of the clock is flagged.
- Sits beside the clock-select path for self-check and status display.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency in Hz. Nominal periods: P1=CLK_HZ, P4=CLK_HZ/4, P8=CLK_HZ/8, P16=CLK_HZ/16 cycles.
- CONFIRM, 2, number of consecutive identical classifications needed to update the code (1..7).

Ports:
- clk  input  1  system clock; rising edge only.
- rst  input  1  asynchronous, active-high reset.
- clk_selected  input  1  slow clock under test; asynchronous to clk.
- freq_code  output  2  detected code: 00=1Hz, 01=4Hz, 10=8Hz, 11=16Hz.
- code_valid  output  1  high while a confirmed code is held and the signal is present.
- code_change  output  1  one-cycle pulse when freq_code takes a new confirmed value.
- period_count  output  CNT_W  last accepted period in clk cycles.
- sig_lost  output  1  high after timeout with no rising edge.

Behaviour:
- Derived constants:
  - TH_A=3*CLK_HZ/32, TH_B=3*CLK_HZ/16, TH_C=5*CLK_HZ/8.
  - MIN_P=CLK_HZ/32, TIMEOUT=2*CLK_HZ.
  - CNT_W=$clog2(TIMEOUT+1).
  - All integer division truncates.
- Reset: freq_code=00, code_valid=0, code_change=0, period_count=0, sig_lost=0. Synchroniser, counter, confirm counter and FSM are all cleared. Reset asserted mid-measurement discards everything immediately.
- Input path:
  - 2-FF synchroniser, then a registered edge detector.
  - rise=1 for exactly one clk cycle per clk_selected rising edge, 3 cycles after the pin edge.
- Period counter: increments every cycle in S_MEASURE and saturates at TIMEOUT. On rise it is captured as P and restarts at 1 in the same cycle.
- Classification of P, evaluated in the rise cycle:
  - P<MIN_P: glitch. Rejected, confirm counter cleared, outputs unchanged.
  - P<=TH_A: 11. P<=TH_B: 10. P<=TH_C: 01. Otherwise: 00.
  - Equality falls into the faster class.
- FSM states:
  - S_WAIT: counter idle. On rise go to S_MEASURE, counter=1, no classification.
  - S_MEASURE: on rise, classify. If the class equals the previous candidate, confirm++; else candidate=class and confirm=1.
  - When confirm reaches CONFIRM and candidate≠freq_code or code_valid=0: on the next cycle (rise+1) load freq_code, code_valid=1, pulse code_change. period_count updates on rise+1 for every accepted (non-glitch) P.
  - Counter reaches TIMEOUT without rise: go to S_WAIT next cycle, code_valid=0, sig_lost=1, confirm cleared. freq_code holds its last value.
  - sig_lost clears on the next rise.
- Re-confirmation of an unchanged code does not pulse code_change.
- A valid code that stays valid through a frequency switch keeps the old code until the new one is confirmed. code_valid stays 1 during the switch.
- Simultaneous rise and timeout in the same cycle: rise wins. The period is classified as 00, since P=TIMEOUT>TH_C.
- Total latency from the first edge: a lock needs CONFIRM+1 rising edges. Outputs update 4 clk cycles after the last pin edge.

Decomposition:
- Shared package freq_sel_pkg holds:
  - code localparams FREQ_1HZ=2'b00, FREQ_4HZ=2'b01, FREQ_8HZ=2'b10, FREQ_16HZ=2'b11, shared with the multiplexer select logic;
  - the FSM state encoding S_WAIT/S_MEASURE.
- One sub-module, sync_edge_detect: 2-FF synchroniser plus rising-edge pulse, with async active-high reset.
- Counter, classifier and FSM stay in freq_detector.

Test Plan:
All tests use CLK_HZ=1600 and CONFIRM=2, giving P1=1600, P4=400, P8=200, P16=100, TH_A=150, TH_B=300, TH_C=1000, MIN_P=50, TIMEOUT=3200.
1. Reset, then a 16 Hz square wave (period 100) -> code_valid=1 and freq_code=11 after the 3rd rising edge, with one code_change pulse and period_count=100.
2. Switch the input from 16 Hz to 4 Hz (period 400) -> freq_code stays 11 for one 400 period, becomes 01 after the second 400 period with one code_change, and code_valid never drops.
3. Inject a 20-cycle glitch pulse into a locked 8 Hz stream -> the P<50 period is rejected, freq_code stays 10 with no code_change, and re-lock completes after 2 clean periods.
4. Boundary periods of 150, 151, 300, 1000 and 1001 cycles, each repeated twice -> codes 11, 10, 10, 01 and 00 respectively.
5. Hold the input low for 3200 cycles after a 1 Hz lock -> sig_lost=1 and code_valid=0 one cycle after saturation, freq_code holds 00. The next edge clears sig_lost, and 2 further periods restore valid.
6. Assert rst mid-period while locked on 8 Hz -> all outputs go to their reset values immediately. After release, 3 edges are needed before code_valid=1.
